// File: rtl/rgb_yuv_encoder.sv
// rgb_yuv_encoder
// Reads an interleaved 8-bit RGB frame from a single-port SRAM. Each group of
// four pixels comes from six 16-bit words. The encoder writes four Y samples
// and one horizontally subsampled U/V pair per two pixels back into separate
// Y, U and V planes. Every group takes a fixed 20-cycle schedule:
// six reads, Y/U/V arithmetic, then four writes.
//
// Ports
//   Clock            single rising-edge clock
//   Reset            synchronous, active-high
//   Enable           frame start request, looked at only while idle
//   SRAM_address     registered SRAM address
//   SRAM_read_data   SRAM read data, two cycles behind the address
//   SRAM_write_data  registered SRAM write data
//   SRAM_we_n        registered active-low write strobe
//   Done             one-cycle pulse when the whole frame has been written
module rgb_yuv_encoder #(
  parameter logic [17:0] RGB_BASE = 18'd146944,
  parameter logic [17:0] Y_BASE   = 18'd0,
  parameter logic [17:0] U_BASE   = 18'd38400,
  parameter logic [17:0] V_BASE   = 18'd57600,
  parameter int          GROUPS   = 19200
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Done
);

  typedef enum logic [1:0] {IDLE, GROUP, DONE} state_t;

  state_t             state;
  logic [17:0]        g;
  logic [4:0]         k;
  logic [17:0]        rd_ptr;
  logic [15:0]        src_word [0:5];
  logic [7:0]         res [0:7];

  logic [7:0]         px_r [0:3];
  logic [7:0]         px_g [0:3];
  logic [7:0]         px_b [0:3];
  logic               luma;
  logic               chroma;
  logic [8:0]         op_a, op_b, op_c;
  logic signed [17:0] coef_a, coef_b, coef_c;
  logic signed [31:0] prod_a, prod_b, prod_c;
  logic signed [31:0] sum;
  logic signed [31:0] scaled;
  logic [7:0]         clamped;
  logic               last_group;

  // Split the six captured words back into the byte stream R,G,B,R,G,B,...
  // and pick the multiplier operands for the current schedule slot.
  // k=8..11 produce Y0..Y3; k=12,13 produce U0,U1; k=14,15 produce V0,V1.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      px_r[2*i]   = src_word[3*i][15:8];
      px_g[2*i]   = src_word[3*i][7:0];
      px_b[2*i]   = src_word[3*i+1][15:8];
      px_r[2*i+1] = src_word[3*i+1][7:0];
      px_g[2*i+1] = src_word[3*i+2][15:8];
      px_b[2*i+1] = src_word[3*i+2][7:0];
    end

    luma   = (k[4:2] == 3'b010);
    chroma = (k[4:2] == 3'b011);

    op_a   = '0;
    op_b   = '0;
    op_c   = '0;
    coef_a = '0;
    coef_b = '0;
    coef_c = '0;

    if (luma) begin
      op_a   = {1'b0, px_r[k[1:0]]};
      op_b   = {1'b0, px_g[k[1:0]]};
      op_c   = {1'b0, px_b[k[1:0]]};
      coef_a = 18'sd16843;
      coef_b = 18'sd33030;
      coef_c = 18'sd6423;
    end else if (chroma) begin
      // Chroma works on the sum of two horizontally adjacent pixels.
      // That is why its shift is one bit wider than the luma shift.
      op_a = {1'b0, px_r[{k[0], 1'b0}]} + {1'b0, px_r[{k[0], 1'b1}]};
      op_b = {1'b0, px_g[{k[0], 1'b0}]} + {1'b0, px_g[{k[0], 1'b1}]};
      op_c = {1'b0, px_b[{k[0], 1'b0}]} + {1'b0, px_b[{k[0], 1'b1}]};
      if (!k[1]) begin
        coef_a = -18'sd9699;
        coef_b = -18'sd19071;
        coef_c = 18'sd28770;
      end else begin
        coef_a = 18'sd28770;
        coef_b = -18'sd24117;
        coef_c = -18'sd4653;
      end
    end
  end

  // Three shared multipliers. The 9-bit operands are unsigned, so each one
  // gets a zero bit in front before the signed multiply.
  always_comb begin
    prod_a = 32'($signed({1'b0, op_a})) * 32'(coef_a);
    prod_b = 32'($signed({1'b0, op_b})) * 32'(coef_b);
    prod_c = 32'($signed({1'b0, op_c})) * 32'(coef_c);
    sum    = prod_a + prod_b + prod_c + (luma ? 32'sd32768 : 32'sd65536);
    scaled = luma ? ((sum >>> 16) + 32'sd16) : ((sum >>> 17) + 32'sd128);
    if (scaled < 32'sd0) begin
      clamped = 8'd0;
    end else if (scaled > 32'sd255) begin
      clamped = 8'd255;
    end else begin
      clamped = scaled[7:0];
    end
  end

  assign last_group = (g == 18'(GROUPS - 1));

  // Frame sequencer. Each SRAM output is loaded one cycle ahead of the slot
  // in which it must appear. So the read addresses for k=1..5 are issued at
  // k=0..4, and the write for slot k+1 is set up during slot k.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state           <= IDLE;
      g               <= '0;
      k               <= '0;
      rd_ptr          <= '0;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      Done            <= 1'b0;
      for (int i = 0; i < 6; i++) src_word[i] <= '0;
      for (int i = 0; i < 8; i++) res[i] <= '0;
    end else begin
      Done      <= 1'b0;
      SRAM_we_n <= 1'b1;
      case (state)
        IDLE: begin
          if (Enable) begin
            state        <= GROUP;
            g            <= '0;
            k            <= '0;
            SRAM_address <= RGB_BASE;
            rd_ptr       <= RGB_BASE + 18'd1;
          end
        end

        GROUP: begin
          // Read data shows up two slots after its address. Shifting it in
          // lands word 0 in src_word[0] after six captures.
          if (k >= 5'd2 && k <= 5'd7) begin
            for (int i = 0; i < 5; i++) src_word[i] <= src_word[i+1];
            src_word[5] <= SRAM_read_data;
          end

          if (luma || chroma) res[k[2:0]] <= clamped;

          case (k)
            5'd15: begin
              SRAM_address    <= Y_BASE + {g[16:0], 1'b0};
              SRAM_write_data <= {res[0], res[1]};
              SRAM_we_n       <= 1'b0;
            end
            5'd16: begin
              SRAM_address    <= Y_BASE + {g[16:0], 1'b1};
              SRAM_write_data <= {res[2], res[3]};
              SRAM_we_n       <= 1'b0;
            end
            5'd17: begin
              SRAM_address    <= U_BASE + g;
              SRAM_write_data <= {res[4], res[5]};
              SRAM_we_n       <= 1'b0;
            end
            5'd18: begin
              SRAM_address    <= V_BASE + g;
              SRAM_write_data <= {res[6], res[7]};
              SRAM_we_n       <= 1'b0;
            end
            default: begin
            end
          endcase

          if (k == 5'd19) begin
            k <= '0;
            if (last_group) begin
              state <= DONE;
              Done  <= 1'b1;
            end else begin
              g            <= g + 18'd1;
              SRAM_address <= rd_ptr;
              rd_ptr       <= rd_ptr + 18'd1;
            end
          end else begin
            k <= k + 5'd1;
            if (k < 5'd5) begin
              SRAM_address <= rd_ptr;
              rd_ptr       <= rd_ptr + 18'd1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rgb_yuv_encoder.md
RGB_YUV_ENCODER -- requirements
Module: rgb_yuv_encoder

Interface
REQ-001 SHALL have parameter RGB_BASE, default 18'd146944, meaning the first word of the interleaved RGB source image.
REQ-002 SHALL have parameter Y_BASE, default 18'd0, meaning the first word of the Y destination plane.
REQ-003 SHALL have parameter U_BASE, default 18'd38400, meaning the first word of the U destination plane.
REQ-004 SHALL have parameter V_BASE, default 18'd57600, meaning the first word of the V destination plane.
REQ-005 SHALL have parameter GROUPS, default 19200, meaning the number of 4-pixel groups per frame (320x240 image).
REQ-006 SHALL have port Clock, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port Reset, input, 1 bit; reset is synchronous and active-high.
REQ-008 SHALL have port Enable, input, 1 bit, frame start, sampled only in IDLE.
REQ-009 SHALL have port SRAM_address, output, 18 bits, registered.
REQ-010 SHALL have port SRAM_read_data, input, 16 bits.
REQ-011 SHALL have port SRAM_write_data, output, 16 bits, registered.
REQ-012 SHALL have port SRAM_we_n, output, 1 bit, active-low write strobe, registered.
REQ-013 SHALL have port Done, output, 1 bit, one-cycle frame-complete pulse.

Function
REQ-014 SHALL use states IDLE, GROUP (20-cycle loop, group counter g, cycle counter k=0..19) and DONE; IDLE->GROUP when Enable=1, with g=0 and k=0.
REQ-015 SHALL treat source words per group g as RGB_BASE+6g+{0..5}: {R0,G0},{B0,R1},{G1,B1},{R2,G2},{B2,R3},{G3,B3}, where [15:8] is the first byte.
REQ-016 SHALL, in GROUP k=0..5, present SRAM_address=RGB_BASE+6g+k with SRAM_we_n=1.
REQ-017 SHALL treat SRAM read latency as 2 cycles: data for the address presented in cycle k is valid during cycle k+2 and is captured at the end of k+2 (k+2 = 2..7).
REQ-018 SHALL instantiate three signed 32-bit multipliers, each with a 9-bit unsigned operand and an 18-bit signed coefficient; only one product triple is used per cycle.
REQ-019 SHALL compute, for k=8..11, Yi = clamp(((16843R+33030G+6423B+32768)>>>16)+16) for pixels 0..3 respectively.
REQ-020 SHALL use pair sums for chroma: Rs=R(2p)+R(2p+1), and likewise Gs and Bs, for pair p=0,1.
REQ-021 SHALL compute, for k=12..13, Up = clamp(((-9699Rs-19071Gs+28770Bs+65536)>>>17)+128) for p=0,1.
REQ-022 SHALL compute, for k=14..15, Vp = clamp(((28770Rs-24117Gs-4653Bs+65536)>>>17)+128) for p=0,1.
REQ-023 SHALL define clamp as: negative -> 0, >255 -> 255, else the low 8 bits; >>> is an arithmetic (flooring) shift.
REQ-024 SHALL, in GROUP k=16..19, hold SRAM_we_n=0 and write the following, one per cycle:
- k=16: {Y0,Y1} at Y_BASE+2g
- k=17: {Y2,Y3} at Y_BASE+2g+1
- k=18: {U0,U1} at U_BASE+g
- k=19: {V0,V1} at V_BASE+g
REQ-025 SHALL hold SRAM_we_n=1 in every cycle other than k=16..19.
REQ-026 SHALL, at k=19, go to k=0 with g+1 if g<GROUPS-1, else go to DONE.
REQ-027 SHALL, in DONE, assert Done=1 for exactly one cycle and then return to IDLE; Done is 0 in all other states.
REQ-028 SHALL ignore Enable outside IDLE; if Enable is held high, a new frame starts in the cycle after returning to IDLE.
REQ-029 SHALL give a frame latency of exactly GROUPS*20 cycles from the first GROUP cycle to the DONE cycle (384000 at the defaults).

Reset
REQ-030 SHALL, when Reset=1 at a clock edge, set state=IDLE, g=0, k=0, SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, Done=0, and clear the capture and result registers.
REQ-031 SHALL let Reset take priority over all other inputs; a reset mid-frame aborts with no further writes and no Done pulse.

Verification
REQ-032 SHALL cover: all source words 0x0000 -> every Y word 0x1010, every U/V word 0x8080, Done pulse at cycle 384000.
REQ-033 SHALL cover: all source words 0xFFFF -> Y words 0xEBEB, U/V words 0x8080.
REQ-034 SHALL cover: group 0 words FF00,00FF,0000 repeated (pure red) -> Y_BASE+0/+1 = 0x5252, U_BASE = 0x5A5A, V_BASE = 0xF0F0.
REQ-035 SHALL cover: final group -> writes at addresses 38398, 38399, 57599 and 76799 in k=16..19, then Done=1 for one cycle, then IDLE.
REQ-036 SHALL cover: Enable pulsed during group 3 -> no effect; Reset asserted at group 5, k=17 -> SRAM_we_n=1 and SRAM_address=0 on the next cycle, no Done pulse, and state IDLE.
